// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD read scheduler: FSM states, sector size,
// default timeouts and the byte-counter width.
package sd_sched_pkg;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DONE,
    S_FAULT,
    S_DEAD
  } state_e;

  localparam int BLOCK_BYTES       = 512;
  localparam int START_TIMEOUT_DEF = 1024;
  localparam int XFER_TIMEOUT_DEF  = 2000000;
  localparam int BYTE_CNT_W        = 17;

  // 255 blocks * 512 bytes: the largest length a request can ask for
  localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = 17'd130560;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the port not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // last_q = 1 means port 1 was granted last, so port 0 has priority after reset
  logic last_q, last_d;

  always_comb begin
    gnt_o  = req_i;
    last_d = last_q;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    if (advance_i && gnt_o != 2'b00) last_d = gnt_o[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/sd_read_scheduler.sv
// Shares one SPI SD sector reader between two requesters: round-robin accept,
// drives the reader, steers its byte stream and reports completion/length errors.
module sd_read_scheduler
  import sd_sched_pkg::*;
#(
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int XFER_TIMEOUT  = XFER_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_sector,
  input  logic [7:0]  req0_blocks,
  output logic        req0_ready,
  output logic [7:0]  req0_data,
  output logic        req0_data_valid,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [31:0] req1_sector,
  input  logic [7:0]  req1_blocks,
  output logic        req1_ready,
  output logic [7:0]  req1_data,
  output logic        req1_data_valid,
  output logic        req1_done,
  output logic        req1_err,
  output logic        rd_start,
  output logic [31:0] rd_sector,
  output logic [7:0]  rd_count,
  input  logic [7:0]  rd_data,
  input  logic        rd_data_valid,
  input  logic        rd_busy,
  input  logic        rd_error,
  output logic [1:0]  grant,
  output logic        sched_busy,
  output logic        sched_fault
);

  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (v >= BYTE_CNT_MAX) ? v : v + BYTE_CNT_W'(1);
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           sector_q, sector_d;
  logic [7:0]            blocks_q, blocks_d;
  logic [1:0]            grant_q, grant_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]           tmr_q, tmr_d;
  logic                  low_q, low_d;
  logic [1:0]            zdone_q, zdone_d;
  logic                  fault_q, fault_d;
  logic [7:0]            d0_q, d1_q;
  logic [1:0]            dv_q;

  logic [1:0]            arb_req, arb_gnt;
  logic [7:0]            win_blocks;
  logic [31:0]           win_sector;
  logic [BYTE_CNT_W-1:0] exp_bytes;
  logic                  active, end_pulse, len_err;

  assign arb_req    = (state_q == S_IDLE || state_q == S_DEAD) ? {req1_valid, req0_valid} : 2'b00;
  assign win_blocks = arb_gnt[1] ? req1_blocks : req0_blocks;
  assign win_sector = arb_gnt[1] ? req1_sector : req0_sector;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .advance_i (|arb_gnt),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    sector_d   = sector_q;
    blocks_d   = blocks_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    tmr_d      = tmr_q;
    low_d      = low_q;
    zdone_d    = 2'b00;
    fault_d    = fault_q;
    case (state_q)
      S_WAIT_INIT: begin
        low_d = !rd_busy;
        if (rd_error)               state_d = S_FAULT;
        else if (!rd_busy && low_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          if (win_blocks == 8'd0) begin
            zdone_d = arb_gnt;
          end else begin
            sector_d = win_sector;
            blocks_d = win_blocks;
            grant_d  = arb_gnt;
            tmr_d    = 32'd0;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmr_d = tmr_q + 32'd1;
        if (rd_error) begin
          state_d = S_FAULT;
        end else if (rd_busy) begin
          byte_cnt_d = '0;
          tmr_d      = 32'd0;
          state_d    = S_STREAM;
        end else if (tmr_q == 32'(START_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_STREAM: begin
        if (rd_data_valid) begin
          byte_cnt_d = sat_inc(byte_cnt_q);
          tmr_d      = 32'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
        // a byte arriving with busy already low is still presented before done
        if (rd_error)                                            state_d = S_FAULT;
        else if (!rd_busy && !rd_data_valid)                     state_d = S_DONE;
        else if (!rd_data_valid && tmr_q + 32'd1 == 32'(XFER_TIMEOUT)) state_d = S_FAULT;
      end
      S_DONE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        grant_d = 2'b00;
        fault_d = 1'b1;
        state_d = S_DEAD;
      end
      S_DEAD: begin
        zdone_d = arb_gnt;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT_INIT;
      sector_q   <= '0;
      blocks_q   <= '0;
      grant_q    <= 2'b00;
      byte_cnt_q <= '0;
      tmr_q      <= '0;
      low_q      <= 1'b0;
      zdone_q    <= 2'b00;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sector_q   <= sector_d;
      blocks_q   <= blocks_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      tmr_q      <= tmr_d;
      low_q      <= low_d;
      zdone_q    <= zdone_d;
      fault_q    <= fault_d;
    end
  end

  // stream steering: one cycle of latency, only the owner sees strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
      dv_q <= 2'b00;
    end else begin
      dv_q <= (state_q == S_STREAM && rd_data_valid) ? grant_q : 2'b00;
      if (state_q == S_STREAM && rd_data_valid && grant_q[0]) d0_q <= rd_data;
      if (state_q == S_STREAM && rd_data_valid && grant_q[1]) d1_q <= rd_data;
    end
  end

  assign active    = (state_q == S_ISSUE) || (state_q == S_STREAM) || (state_q == S_DONE);
  assign end_pulse = (state_q == S_DONE) || (state_q == S_FAULT);
  assign exp_bytes = BYTE_CNT_W'(blocks_q) * BYTE_CNT_W'(BLOCK_BYTES);
  assign len_err   = (state_q == S_FAULT) || (byte_cnt_q != exp_bytes);

  assign req0_ready      = arb_gnt[0];
  assign req1_ready      = arb_gnt[1];
  assign req0_data       = d0_q;
  assign req1_data       = d1_q;
  assign req0_data_valid = dv_q[0];
  assign req1_data_valid = dv_q[1];
  assign req0_done       = zdone_q[0] | (end_pulse & grant_q[0]);
  assign req1_done       = zdone_q[1] | (end_pulse & grant_q[1]);
  assign req0_err        = zdone_q[0] | (end_pulse & grant_q[0] & len_err);
  assign req1_err        = zdone_q[1] | (end_pulse & grant_q[1] & len_err);
  assign rd_start        = (state_q == S_ISSUE);
  assign rd_sector       = active ? sector_q : 32'd0;
  assign rd_count        = active ? blocks_q : 8'd0;
  assign grant           = grant_q;
  assign sched_busy      = (state_q != S_IDLE);
  assign sched_fault     = fault_q;

endmodule
